// File: rtl/atm_bank_arbiter_pkg.sv
// atm_bank_arbiter_pkg
// Shared definitions for the ATM balance-bank controller:
//   - opcode values carried on req_op
//   - status codes returned on rsp_status
//   - FSM state encoding used by atm_bank_arbiter
//   - field widths and a small opcode-legality helper
package atm_bank_arbiter_pkg;

    localparam int OP_W  = 3;
    localparam int ACC_W = 4;
    localparam int ST_W  = 3;

    // Request opcodes; every other value is rejected with ST_BAD_OP.
    localparam logic [OP_W-1:0] OP_BALANCE  = 3'd1;
    localparam logic [OP_W-1:0] OP_WITHDRAW = 3'd2;
    localparam logic [OP_W-1:0] OP_DEPOSIT  = 3'd3;

    // Response status codes.
    localparam logic [ST_W-1:0] ST_OK       = 3'd0;
    localparam logic [ST_W-1:0] ST_INSUFF   = 3'd1;
    localparam logic [ST_W-1:0] ST_BAD_ACC  = 3'd2;
    localparam logic [ST_W-1:0] ST_BAD_OP   = 3'd3;
    localparam logic [ST_W-1:0] ST_OVERFLOW = 3'd4;

    // Transaction FSM: one state per cycle of the 4-cycle transaction.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_EXEC  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op == OP_BALANCE) || (op == OP_WITHDRAW) || (op == OP_DEPOSIT);
    endfunction

endpackage

// File: rtl/atm_bank_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker. Searches req starting at index ptr and
// wrapping around; the first set bit wins.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  index with highest priority this round (must be < N)
//   gnt  out N   one-hot grant (all zero when req is zero)
//   idx  out IW  encoded index of the granted bit (0 when req is zero)
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            // Candidate index ptr+k, wrapped modulo N without a divider.
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/atm_bank_arbiter.sv
// atm_bank_arbiter
// Shared balance bank for N_TERM ATM terminals. Requests are arbitrated
// round-robin; the winner's operation is executed as an atomic
// read-check-write on one of N_ACC balances, and status plus resulting
// balance are returned with a one-cycle done pulse.
// Transaction: IDLE -> LATCH -> EXEC -> RESP -> IDLE (4 cycles).
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   req          in   N_TERM        per-terminal request, held until done
//   req_op       in   3*N_TERM      packed opcodes
//   req_acc      in   4*N_TERM      packed account indices
//   req_amt      in   BAL_W*N_TERM  packed amounts
//   gnt          out  N_TERM        one-hot, high for the whole transaction
//   done         out  N_TERM        one-hot, one-cycle completion pulse
//   rsp_status   out  3             status, valid with done
//   rsp_balance  out  BAL_W         post-operation balance, valid with done
//   busy         out  1             high whenever the FSM is not IDLE
module atm_bank_arbiter
    import atm_bank_arbiter_pkg::*;
#(
    parameter int N_TERM   = 4,
    parameter int N_ACC    = 10,
    parameter int BAL_W    = 32,
    parameter int INIT_BAL = 500
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TERM-1:0]         req,
    input  logic [OP_W*N_TERM-1:0]    req_op,
    input  logic [ACC_W*N_TERM-1:0]   req_acc,
    input  logic [BAL_W*N_TERM-1:0]   req_amt,
    output logic [N_TERM-1:0]         gnt,
    output logic [N_TERM-1:0]         done,
    output logic [ST_W-1:0]           rsp_status,
    output logic [BAL_W-1:0]          rsp_balance,
    output logic                      busy
);

    localparam int                IW       = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam logic [BAL_W-1:0]  INIT_VAL = BAL_W'(INIT_BAL);

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       win_q;
    logic [N_TERM-1:0]   gnt_q;
    logic [N_TERM-1:0]   done_q;
    logic [OP_W-1:0]     op_q;
    logic [ACC_W-1:0]    acc_q;
    logic [BAL_W-1:0]    amt_q;
    logic [ST_W-1:0]     rsp_status_q;
    logic [BAL_W-1:0]    rsp_balance_q;

    logic [N_TERM-1:0]   arb_gnt;
    logic [IW-1:0]       arb_idx;

    logic [OP_W-1:0]     op_arr  [N_TERM];
    logic [ACC_W-1:0]    acc_arr [N_TERM];
    logic [BAL_W-1:0]    amt_arr [N_TERM];
    logic [BAL_W-1:0]    bal_vec [N_ACC];

    logic [BAL_W-1:0]    cur_bal;
    logic [BAL_W:0]      sum;
    logic                acc_ok;
    logic [ST_W-1:0]     exec_status;
    logic [BAL_W-1:0]    exec_bal;
    logic                exec_wr;

    // Unpack the per-terminal request fields so the winner can be indexed.
    for (genvar gi = 0; gi < N_TERM; gi++) begin : gen_unpack
        assign op_arr[gi]  = req_op[OP_W*gi +: OP_W];
        assign acc_arr[gi] = req_acc[ACC_W*gi +: ACC_W];
        assign amt_arr[gi] = req_amt[BAL_W*gi +: BAL_W];
    end

    rr_arbiter #(
        .N  (N_TERM),
        .IW (IW)
    ) u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|req) state_d = S_LATCH;
            S_LATCH: state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy        = (state_q != S_IDLE);
        gnt         = gnt_q;
        done        = done_q;
        rsp_status  = rsp_status_q;
        rsp_balance = rsp_balance_q;
    end

    // ---------------- Execute: read-check on the latched request ----------------
    always_comb begin
        cur_bal = '0;
        for (int k = 0; k < N_ACC; k++) begin
            if (acc_q == ACC_W'(k)) begin
                cur_bal = bal_vec[k];
            end
        end
        acc_ok      = (int'(acc_q) < N_ACC);
        // One extra bit so a deposit overflow shows up as a carry.
        sum         = {1'b0, cur_bal} + {1'b0, amt_q};
        exec_status = ST_OK;
        exec_bal    = cur_bal;
        exec_wr     = 1'b0;
        if (!acc_ok) begin
            exec_status = ST_BAD_ACC;
            exec_bal    = '0;
        end else if (!is_legal_op(op_q)) begin
            exec_status = ST_BAD_OP;
        end else if (op_q == OP_BALANCE) begin
            exec_status = ST_OK;
        end else if (op_q == OP_WITHDRAW) begin
            if (amt_q > cur_bal) begin
                exec_status = ST_INSUFF;
            end else begin
                exec_bal = cur_bal - amt_q;
                exec_wr  = 1'b1;
            end
        end else begin
            if (sum[BAL_W]) begin
                exec_status = ST_OVERFLOW;
            end else begin
                exec_bal = sum[BAL_W-1:0];
                exec_wr  = 1'b1;
            end
        end
    end

    // ---------------- Transaction datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q         <= '0;
            win_q         <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            op_q          <= '0;
            acc_q         <= '0;
            amt_q         <= '0;
            rsp_status_q  <= '0;
            rsp_balance_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        gnt_q <= arb_gnt;
                        win_q <= arb_idx;
                    end
                end
                S_LATCH: begin
                    // Captured here so later changes on req_* (or req
                    // dropping) cannot disturb the transaction.
                    op_q  <= op_arr[win_q];
                    acc_q <= acc_arr[win_q];
                    amt_q <= amt_arr[win_q];
                    ptr_q <= (win_q == IW'(N_TERM - 1)) ? '0 : win_q + IW'(1);
                end
                S_EXEC: begin
                    done_q        <= gnt_q;
                    rsp_status_q  <= exec_status;
                    rsp_balance_q <= exec_bal;
                end
                S_RESP: begin
                    done_q <= '0;
                    gnt_q  <= '0;
                end
                default: begin
                    gnt_q  <= '0;
                    done_q <= '0;
                end
            endcase
        end
    end

    // ---------------- Balance storage ----------------
    // Registers rather than RAM: every account must reload INIT_BAL on reset.
    for (genvar gi = 0; gi < N_ACC; gi++) begin : gen_acc
        logic [BAL_W-1:0] bal_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                bal_q <= INIT_VAL;
            end else if ((state_q == S_EXEC) && exec_wr && (acc_q == ACC_W'(gi))) begin
                bal_q <= exec_bal;
            end
        end

        assign bal_vec[gi] = bal_q;
    end

endmodule

// File: tb/tb_atm_bank_arbiter.sv
// tb_atm_bank_arbiter
// Directed bench for atm_bank_arbiter: a table of single-terminal
// transactions (applied in order, balances carry over between rows) plus
// hand-written sequences for 4-way contention with re-request fairness
// and reset in the middle of a transaction.
module tb_atm_bank_arbiter;
    import atm_bank_arbiter_pkg::*;

    localparam int NT = 4;
    localparam int NA = 10;
    localparam int BW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NT-1:0]     req = '0;
    logic [3*NT-1:0]   req_op = '0;
    logic [4*NT-1:0]   req_acc = '0;
    logic [BW*NT-1:0]  req_amt = '0;
    logic [NT-1:0]     gnt;
    logic [NT-1:0]     done;
    logic [2:0]        rsp_status;
    logic [BW-1:0]     rsp_balance;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    atm_bank_arbiter #(
        .N_TERM   (NT),
        .N_ACC    (NA),
        .BAL_W    (BW),
        .INIT_BAL (500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_op      (req_op),
        .req_acc     (req_acc),
        .req_amt     (req_amt),
        .gnt         (gnt),
        .done        (done),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance),
        .busy        (busy)
    );

    typedef struct {
        int          term;
        logic [2:0]  op;
        logic [3:0]  acc;
        logic [31:0] amt;
        logic [2:0]  st;
        logic [31:0] bal;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input int t, input logic [2:0] op, input logic [3:0] acc,
                              input logic [31:0] amt);
        req_op[3*t +: 3]   = op;
        req_acc[4*t +: 4]  = acc;
        req_amt[BW*t +: BW] = amt;
    endtask

    // One transaction from terminal t alone; other terminals carry garbage
    // fields that must be ignored. Called and returns at a negedge.
    task automatic run_txn(input int idx, input int t, input logic [2:0] op, input logic [3:0] acc,
                           input logic [31:0] amt, input logic [2:0] exp_st, input logic [31:0] exp_bal);
        int            cyc;
        bit            seen;
        logic [NT-1:0] oh;
        string         tag;
        tag = $sformatf("txn%0d", idx);
        for (int k = 0; k < NT; k++) begin
            if (k != t) set_fields(k, 3'($urandom), 4'($urandom), $urandom);
        end
        set_fields(t, op, acc, amt);
        oh    = '0;
        oh[t] = 1'b1;
        req   = oh;
        seen  = 1'b0;
        cyc   = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            check({tag, " busy"}, 64'(busy), 64'(1));
            if (done != '0) seen = 1'b1;
        end
        check({tag, " done_seen"}, 64'(seen), 64'(1));
        check({tag, " latency"}, 64'(cyc), 64'(3));
        check({tag, " done"}, 64'(done), 64'(oh));
        check({tag, " gnt"}, 64'(gnt), 64'(oh));
        check({tag, " status"}, 64'(rsp_status), 64'(exp_st));
        check({tag, " balance"}, 64'(rsp_balance), 64'(exp_bal));
        $display("[TB] txn%0d term=%0d op=%0d acc=%0d amt=%0h -> status=%0d balance=%0h",
                 idx, t, op, acc, amt, rsp_status, rsp_balance);
        req = '0;
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'(0));
        check({tag, " idle_busy"}, 64'(busy), 64'(0));
        check({tag, " idle_gnt"}, 64'(gnt), 64'(0));
    endtask

    initial begin
        int          ord  [5];
        logic [31:0] obal [5];
        logic [2:0]  oop  [5];
        logic [NT-1:0] oh;
        int          got;
        int          cyc;

        tbl[0]  = '{0, OP_BALANCE,  4'd3,  32'd0,          ST_OK,       32'd500};
        tbl[1]  = '{1, OP_WITHDRAW, 4'd2,  32'd200,        ST_OK,       32'd300};
        tbl[2]  = '{1, OP_WITHDRAW, 4'd2,  32'd400,        ST_INSUFF,   32'd300};
        tbl[3]  = '{2, OP_DEPOSIT,  4'd5,  32'hFFFF_FF00,  ST_OVERFLOW, 32'd500};
        tbl[4]  = '{2, OP_DEPOSIT,  4'd5,  32'd100,        ST_OK,       32'd600};
        tbl[5]  = '{3, OP_BALANCE,  4'd12, 32'd0,          ST_BAD_ACC,  32'd0};
        tbl[6]  = '{3, 3'd6,        4'd1,  32'd0,          ST_BAD_OP,   32'd500};
        tbl[7]  = '{0, OP_WITHDRAW, 4'd7,  32'd0,          ST_OK,       32'd500};
        tbl[8]  = '{1, OP_DEPOSIT,  4'd7,  32'd0,          ST_OK,       32'd500};
        tbl[9]  = '{2, OP_WITHDRAW, 4'd7,  32'd500,        ST_OK,       32'd0};
        tbl[10] = '{3, OP_DEPOSIT,  4'd6,  32'hFFFF_FE0B,  ST_OK,       32'hFFFF_FFFF};
        tbl[11] = '{0, OP_DEPOSIT,  4'd6,  32'd1,          ST_OVERFLOW, 32'hFFFF_FFFF};
        tbl[12] = '{1, OP_WITHDRAW, 4'd6,  32'hFFFF_FFFF,  ST_OK,       32'd0};
        tbl[13] = '{2, OP_WITHDRAW, 4'd6,  32'd1,          ST_INSUFF,   32'd0};
        tbl[14] = '{3, 3'd0,        4'd15, 32'd5,          ST_BAD_ACC,  32'd0};
        tbl[15] = '{0, 3'd7,        4'd2,  32'd5,          ST_BAD_OP,   32'd300};
        tbl[16] = '{1, OP_BALANCE,  4'd10, 32'd0,          ST_BAD_ACC,  32'd0};
        tbl[17] = '{2, OP_BALANCE,  4'd9,  32'd0,          ST_OK,       32'd500};
        tbl[18] = '{3, OP_BALANCE,  4'd5,  32'd0,          ST_OK,       32'd600};

        // Reset state.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst gnt", 64'(gnt), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst status", 64'(rsp_status), 64'(0));
        check("rst balance", 64'(rsp_balance), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("post-rst busy", 64'(busy), 64'(0));

        for (int i = 0; i < 19; i++) begin
            run_txn(i, tbl[i].term, tbl[i].op, tbl[i].acc, tbl[i].amt, tbl[i].st, tbl[i].bal);
        end

        // Fresh reset so the pointer starts at 0 for the contention test.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // All four withdraw 100 from acc 0; terminal 0 re-requests a balance
        // query and must wait behind 1, 2 and 3.
        ord  = '{0, 1, 2, 3, 0};
        obal = '{32'd400, 32'd300, 32'd200, 32'd100, 32'd100};
        oop  = '{OP_WITHDRAW, OP_WITHDRAW, OP_WITHDRAW, OP_WITHDRAW, OP_BALANCE};
        for (int k = 0; k < NT; k++) set_fields(k, OP_WITHDRAW, 4'd0, 32'd100);
        req = 4'hF;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                oh          = '0;
                oh[ord[got]] = 1'b1;
                check($sformatf("rr%0d done", got), 64'(done), 64'(oh));
                check($sformatf("rr%0d gnt", got), 64'(gnt), 64'(oh));
                check($sformatf("rr%0d status", got), 64'(rsp_status), 64'(ST_OK));
                check($sformatf("rr%0d balance", got), 64'(rsp_balance), 64'(obal[got]));
                $display("[TB] rr%0d term=%0d op=%0d acc=0 -> done=%b status=%0d balance=%0h",
                         got, ord[got], oop[got], done, rsp_status, rsp_balance);
                if (got == 0) begin
                    set_fields(0, OP_BALANCE, 4'd0, 32'd0);
                end else begin
                    req[ord[got]] = 1'b0;
                end
                got++;
            end
        end
        check("rr count", 64'(got), 64'(5));
        req = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset during EXEC of a withdraw: no write, no done.
        set_fields(1, OP_WITHDRAW, 4'd4, 32'd50);
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        check("mid busy_exec", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("mid gnt", 64'(gnt), 64'(0));
        check("mid busy", 64'(busy), 64'(0));
        check("mid done", 64'(done), 64'(0));
        check("mid status", 64'(rsp_status), 64'(0));
        check("mid balance", 64'(rsp_balance), 64'(0));
        @(negedge clk);
        check("mid done_held", 64'(done), 64'(0));
        check("mid busy_held", 64'(busy), 64'(0));
        $display("[TB] reset mid-EXEC term=1 acc=4 -> gnt=%b busy=%b done=%b", gnt, busy, done);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_txn(100, 1, OP_BALANCE, 4'd4, 32'd0, ST_OK, 32'd500);
        run_txn(101, 2, OP_BALANCE, 4'd0, 32'd0, ST_OK, 32'd500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
